// File: rtl/cmp_pkg.sv
// Shared constants and state type for the serial digit-wise comparator controller.
package cmp_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int DIGIT_W = 2;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    RUN  = S_RUN,
    DONE = S_DONE
  } state_t;

endpackage

// File: rtl/greater_than.sv
// 2-bit unsigned magnitude slice: F is high when A > B. Purely combinational.
module greater_than (
  input  logic [1:0] A,
  input  logic [1:0] B,
  output logic       F
);

  assign F = (A > B);

endmodule

// File: rtl/serial_compare_ctrl.sv
// Compares two WIDTH-bit operands one 2-bit digit per clock, MSB first, stopping on the first
// differing digit. done pulses 2..STEPS+1 cycles after start; start is ignored unless IDLE.
module serial_compare_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             a_lt_b
);

  import cmp_pkg::*;

  localparam int STEPS = WIDTH / DIGIT_W;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int IDX_W = $clog2(WIDTH);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_gt;
  logic               r_eq;
  logic               r_lt;

  logic [IDX_W-1:0]   w_lsb;
  logic [DIGIT_W-1:0] w_dig_a;
  logic [DIGIT_W-1:0] w_dig_b;
  logic               w_gt;
  logic               w_lt;
  logic               w_last;

  // Digit index is cnt*2; the cast only narrows when WIDTH==2, where cnt is always 0.
  assign w_lsb   = IDX_W'({r_cnt, 1'b0});
  assign w_dig_a = r_a[w_lsb +: DIGIT_W];
  assign w_dig_b = r_b[w_lsb +: DIGIT_W];
  assign w_last  = (r_cnt == '0);

  greater_than u_gt (.A(w_dig_a), .B(w_dig_b), .F(w_gt));
  greater_than u_lt (.A(w_dig_b), .B(w_dig_a), .F(w_lt));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_gt || w_lt || w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_cnt <= '0;
      r_gt  <= 1'b0;
      r_eq  <= 1'b0;
      r_lt  <= 1'b0;
    end else begin
      if (r_state == IDLE && start) begin
        r_a   <= a;
        r_b   <= b;
        r_cnt <= CNT_W'(STEPS - 1);
      end
      // Result flags change only when the compare resolves, so they hold through IDLE.
      if (r_state == RUN) begin
        if (w_gt) begin
          {r_gt, r_eq, r_lt} <= 3'b100;
        end else if (w_lt) begin
          {r_gt, r_eq, r_lt} <= 3'b001;
        end else if (w_last) begin
          {r_gt, r_eq, r_lt} <= 3'b010;
        end else begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end
    end
  end

  assign busy   = (r_state == RUN);
  assign done   = (r_state == DONE);
  assign a_gt_b = r_gt;
  assign a_eq_b = r_eq;
  assign a_lt_b = r_lt;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed bench for serial_compare_ctrl: WIDTH=8 scenarios plus a WIDTH=2 exhaustive sweep.
module tb_serial_compare_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic       a_gt_b;
  logic       a_eq_b;
  logic       a_lt_b;

  logic       start2;
  logic [1:0] a2;
  logic [1:0] b2;
  logic       busy2;
  logic       done2;
  logic       gt2;
  logic       eq2;
  logic       lt2;

  int n_checks;
  int n_errors;

  serial_compare_ctrl #(.WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .a_gt_b(a_gt_b), .a_eq_b(a_eq_b), .a_lt_b(a_lt_b)
  );

  serial_compare_ctrl #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .a_gt_b(gt2), .a_eq_b(eq2), .a_lt_b(lt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drives one request and watches 20 cycles; lat is the edge count to the first done (0 = none).
  task automatic run_cmp(input logic [7:0] ta, input logic [7:0] tb, input bit inject,
                         output int lat, output int busy_cyc, output int done_cnt);
    a = ta;
    b = tb;
    start = 1'b1;
    lat = 0;
    busy_cyc = 0;
    done_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (inject && i == 1) begin
        a = 8'h00;
        b = 8'hFF;
        start = 1'b1;
      end
      if (busy) busy_cyc++;
      if (done) begin
        done_cnt++;
        if (lat == 0) lat = i;
      end
    end
  endtask

  int lat;
  int bcy;
  int dcnt;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    start = 1'b1;
    a = 8'hFF;
    b = 8'h00;
    start2 = 1'b0;
    a2 = 2'd0;
    b2 = 2'd0;

    // 1: reset, with start held high
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_flags", {a_gt_b, a_eq_b, a_lt_b}, 3'b000);
    @(posedge clk); #1;
    chk("rst_start_busy", busy, 0);
    chk("rst_start_done", done, 0);
    rst_n = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);

    // 2: MSB digit decides
    run_cmp(8'hC0, 8'h40, 1'b0, lat, bcy, dcnt);
    chk("c0_lat", lat, 2);
    chk("c0_flags", {a_gt_b, a_eq_b, a_lt_b}, 3'b100);
    chk("c0_busy", bcy, 1);
    chk("c0_dones", dcnt, 1);

    // 3: only LSB digit differs
    run_cmp(8'h12, 8'h13, 1'b0, lat, bcy, dcnt);
    chk("12_lat", lat, 5);
    chk("12_flags", {a_gt_b, a_eq_b, a_lt_b}, 3'b001);
    chk("12_busy", bcy, 4);

    // 4: equal operands, results hold
    run_cmp(8'hA5, 8'hA5, 1'b0, lat, bcy, dcnt);
    chk("a5_lat", lat, 5);
    chk("a5_flags", {a_gt_b, a_eq_b, a_lt_b}, 3'b010);
    repeat (10) @(posedge clk);
    #1;
    chk("a5_hold", {a_gt_b, a_eq_b, a_lt_b}, 3'b010);

    // 5: start and operand change during RUN are ignored
    run_cmp(8'h01, 8'h00, 1'b1, lat, bcy, dcnt);
    chk("inj_flags", {a_gt_b, a_eq_b, a_lt_b}, 3'b100);
    chk("inj_dones", dcnt, 1);
    chk("inj_lat", lat, 5);

    // 6: reset mid-RUN
    a = 8'h00;
    b = 8'h01;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy_pre", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_flags", {a_gt_b, a_eq_b, a_lt_b}, 3'b000);
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);

    // WIDTH=2 exhaustive sweep
    for (int ia = 0; ia < 4; ia++) begin
      for (int ib = 0; ib < 4; ib++) begin
        a2 = 2'(ia);
        b2 = 2'(ib);
        start2 = 1'b1;
        lat = 0;
        for (int i = 1; i <= 5; i++) begin
          @(posedge clk); #1;
          start2 = 1'b0;
          if (done2 && lat == 0) lat = i;
        end
        chk($sformatf("w2_flags_%0d_%0d", ia, ib), {gt2, eq2, lt2},
            {ia > ib, ia == ib, ia < ib});
        chk($sformatf("w2_lat_%0d_%0d", ia, ib), lat, 2);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
